// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct codes, FSM state encodings and datapath select codes shared by control and datapath.
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  function automatic logic r_funct_ok(input logic [5:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL};
  endfunction
endpackage

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore-style multi-cycle MIPS control FSM; outputs decode the state register,
// gated by mem_ready in FETCH, funct in R_EXEC and opcode legality in DECODE.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               shift_en,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_out
);
  state_t state, nxt;
  logic legal;
  assign legal = (opcode == OP_R) ? r_funct_ok(funct) : opcode inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  assign state_out = STATE_W'(state);
  always_ff @(posedge clk)
    state <= rst ? S_FETCH : nxt;
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = !legal ? S_FETCH :
                        (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                        (opcode == OP_R) ? S_R_EXEC :
                        (opcode == OP_ADDI) ? S_I_EXEC :
                        (opcode == OP_BEQ) ? S_BRANCH : S_JUMP;
      S_MEM_ADDR: nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   nxt = S_R_WB;
      S_I_EXEC:   nxt = S_I_WB;
      default:    nxt = S_FETCH;
    endcase
  end
  // rst gates everything combinationally so an in-flight memory write drops in the reset cycle itself
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    shift_en      = 1'b0;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    if (!rst)
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM2;
          illegal_op = !legal;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          shift_en  = (funct == F_SLL);
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_I_WB: reg_write = 1'b1;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: random instruction streams with random memory stalls and resets,
// checked cycle by cycle against a per-instruction route model through a scoreboard queue.
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       shift_en;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;
  } vec_t;
  logic clk = 1'b0;
  logic rst, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic reg_write, alu_src_a, shift_en, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_out;
  vec_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .shift_en(shift_en), .pc_source(pc_source), .illegal_op(illegal_op), .state_out(state_out)
  );
  // instruction kinds: 0 lw 1 sw 2 add 3 sub 4 and 5 or 6 slt 7 sll 8 addi 9 beq 10 j 11 bad opcode 12 bad funct
  function automatic vec_t expect_vec(input int st, input int kind, input logic mr, input logic r);
    vec_t v = '0;
    v.state = st[3:0];
    if (r) return v;
    case (st)
      0: begin v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = mr; v.pc_write = mr; end
      1: begin v.alu_src_b = 2'b11; v.illegal_op = (kind >= 11); end
      2: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      3: begin v.mem_read = 1; v.iord = 1; end
      4: begin v.reg_write = 1; v.mem_to_reg = 1; end
      5: begin v.mem_write = 1; v.iord = 1; end
      6: begin v.alu_src_a = 1; v.alu_op = 2'b10; v.shift_en = (kind == 7); end
      7: begin v.reg_write = 1; v.reg_dst = 1; end
      8: begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_write_cond = 1; v.pc_source = 2'b01; end
      9: begin v.pc_write = 1; v.pc_source = 2'b10; end
      10: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      11: v.reg_write = 1;
      default: ;
    endcase
    return v;
  endfunction
  always @(negedge clk) begin
    vec_t act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_op, shift_en, pc_source, illegal_op, state_out};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL cycle_vec t=%0t got=%h expected=%h (state got %0d expected %0d)",
                 $time, act, e, act.state, e.state);
      end
    end
  end
  initial begin
    int route[$];
    int directed[$];
    int pos, kind, cur, ninstr;
    logic mr, do_rst, need_new, rst_wr_done;
    logic [5:0] op, fn;
    directed = '{8, 2, 7, 1, 0, 10, 9, 11, 12, 1};
    rst = 1; mem_ready = 0; opcode = 0; funct = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.push_back(expect_vec(0, 0, 1'b0, 1'b1));
    need_new = 1; rst_wr_done = 0; ninstr = 0; pos = 0; kind = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (need_new) begin
        kind = (ninstr < directed.size()) ? directed[ninstr] : int'($urandom_range(0, 12));
        ninstr++;
        fn = 6'($urandom_range(0, 63));
        case (kind)
          0: op = 6'b100011;
          1: op = 6'b101011;
          8: op = 6'b001000;
          9: op = 6'b000100;
          10: op = 6'b000010;
          11: begin
            op = 6'($urandom_range(1, 63));
            while (op inside {6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010})
              op = 6'($urandom_range(1, 63));
          end
          default: op = 6'b000000;
        endcase
        case (kind)
          2: fn = 6'b100000;
          3: fn = 6'b100010;
          4: fn = 6'b100100;
          5: fn = 6'b100101;
          6: fn = 6'b101010;
          7: fn = 6'b000000;
          12: while (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000})
                fn = 6'($urandom_range(0, 63));
          default: ;
        endcase
        case (kind)
          0: route = '{0, 1, 2, 3, 4};
          1: route = '{0, 1, 2, 5};
          8: route = '{0, 1, 10, 11};
          9: route = '{0, 1, 8};
          10: route = '{0, 1, 9};
          11, 12: route = '{0, 1};
          default: route = '{0, 1, 6, 7};
        endcase
        pos = 0;
        need_new = 0;
      end
      cur = route[pos];
      // one forced reset lands in MEM_WR to check that an in-flight store is abandoned
      do_rst = (cur == 5 && !rst_wr_done && ninstr > directed.size()) || ($urandom_range(0, 59) == 0);
      mr = (cur == 0 || cur == 3 || cur == 5) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      rst = do_rst; mem_ready = mr; opcode = op; funct = fn;
      exp_q.push_back(expect_vec(cur, kind, mr, do_rst));
      if (do_rst) begin
        need_new = 1;
        if (cur == 5) rst_wr_done = 1;
      end else if (!((cur == 0 || cur == 3 || cur == 5) && !mr)) begin
        pos++;
        if (pos == route.size()) need_new = 1;
      end
    end
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0 || !rst_wr_done) begin
      miscompares++;
      $display("FAIL drain pending=%0d rst_in_mem_wr=%0d expected pending=0 rst_in_mem_wr=1", exp_q.size(), rst_wr_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
